control_sequencer: RTL and testbench

- Instruction-cycle state machine that directly feeds control_output.
- Generates the 4-bit state code consumed by control_output, stepping through fetch, IR-load and opcode-dependent execute states for every instruction.
- Decodes the opcode field of the instruction register, reports instruction completion and illegal opcodes, and counts retired instructions.

---
 rtl/cpu_ctrl_pkg.sv | 66 ++++++
 rtl/control_sequencer_if.sv | 24 ++
 rtl/opcode_decoder.sv | 24 ++
 rtl/control_sequencer.sv | 104 ++++++++++
 tb/tb_control_sequencer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared instruction-cycle definitions: state codes, opcodes and IR field positions.
// Also used by control_output so that both blocks agree on the state codes.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_HI  = 15;
    localparam int unsigned OPC_LO  = 12;
    localparam int unsigned OPC_W   = OPC_HI - OPC_LO + 1;

    localparam logic [STATE_W-1:0] ST_FETCH0 = 4'b0000;
    localparam logic [STATE_W-1:0] ST_FETCH1 = 4'b1111;
    localparam logic [STATE_W-1:0] ST_DECODE = 4'b0001;
    localparam logic [STATE_W-1:0] ST_LOAD   = 4'b0010;
    localparam logic [STATE_W-1:0] ST_MOVE   = 4'b0011;
    localparam logic [STATE_W-1:0] ST_LDPC   = 4'b0100;
    localparam logic [STATE_W-1:0] ST_BRANCH = 4'b0101;
    localparam logic [STATE_W-1:0] ST_SUB0   = 4'b0110;
    localparam logic [STATE_W-1:0] ST_SUB1   = 4'b0111;
    localparam logic [STATE_W-1:0] ST_SUB2   = 4'b1000;
    localparam logic [STATE_W-1:0] ST_ADD0   = 4'b1001;
    localparam logic [STATE_W-1:0] ST_ADD1   = 4'b1010;
    localparam logic [STATE_W-1:0] ST_ADD2   = 4'b1011;
    localparam logic [STATE_W-1:0] ST_XOR0   = 4'b1100;
    localparam logic [STATE_W-1:0] ST_XOR1   = 4'b1101;
    localparam logic [STATE_W-1:0] ST_XOR2   = 4'b1110;

    localparam logic [OPC_W-1:0] OP_LOAD   = 4'd0;
    localparam logic [OPC_W-1:0] OP_MOVE   = 4'd1;
    localparam logic [OPC_W-1:0] OP_LDPC   = 4'd2;
    localparam logic [OPC_W-1:0] OP_BRANCH = 4'd3;
    localparam logic [OPC_W-1:0] OP_SUB    = 4'd4;
    localparam logic [OPC_W-1:0] OP_ADD    = 4'd5;
    localparam logic [OPC_W-1:0] OP_XOR    = 4'd6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH0 = ST_FETCH0,
        S_FETCH1 = ST_FETCH1,
        S_DECODE = ST_DECODE,
        S_LOAD   = ST_LOAD,
        S_MOVE   = ST_MOVE,
        S_LDPC   = ST_LDPC,
        S_BRANCH = ST_BRANCH,
        S_SUB0   = ST_SUB0,
        S_SUB1   = ST_SUB1,
        S_SUB2   = ST_SUB2,
        S_ADD0   = ST_ADD0,
        S_ADD1   = ST_ADD1,
        S_ADD2   = ST_ADD2,
        S_XOR0   = ST_XOR0,
        S_XOR1   = ST_XOR1,
        S_XOR2   = ST_XOR2
    } state_e;

    typedef struct packed {
        state_e first;
        logic   legal;
    } dec_t;

    // Last execute state of a legal instruction: the cycle that retires it.
    function automatic logic is_final(input state_e s);
        return (s == S_LOAD) || (s == S_MOVE) || (s == S_LDPC) || (s == S_BRANCH) ||
               (s == S_SUB2) || (s == S_ADD2) || (s == S_XOR2);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer handshake bundle: run/instr/step in, state code and status out.
interface control_sequencer_if
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic               run;
    logic [INSTR_W-1:0] instr;
    logic               step;
    logic [STATE_W-1:0] state;
    logic               done;
    logic               illegal;
    logic [CNT_W-1:0]   retired;

    modport master (
        output run, instr, step,
        input  state, done, illegal, retired
    );

    modport slave (
        input  run, instr, step,
        output state, done, illegal, retired
    );
endinterface

// File: rtl/opcode_decoder.sv
// Maps the opcode field to the first execute state; opcodes 7..15 are illegal.
module opcode_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opc_i,
    output dec_t             dec_c_o
);

    always_comb begin
        dec_c_o.first = S_FETCH0;
        dec_c_o.legal = 1'b0;
        case (opc_i)
            OP_LOAD:   begin dec_c_o.first = S_LOAD;   dec_c_o.legal = 1'b1; end
            OP_MOVE:   begin dec_c_o.first = S_MOVE;   dec_c_o.legal = 1'b1; end
            OP_LDPC:   begin dec_c_o.first = S_LDPC;   dec_c_o.legal = 1'b1; end
            OP_BRANCH: begin dec_c_o.first = S_BRANCH; dec_c_o.legal = 1'b1; end
            OP_SUB:    begin dec_c_o.first = S_SUB0;   dec_c_o.legal = 1'b1; end
            OP_ADD:    begin dec_c_o.first = S_ADD0;   dec_c_o.legal = 1'b1; end
            OP_XOR:    begin dec_c_o.first = S_XOR0;   dec_c_o.legal = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Instruction-cycle sequencer: fetch, decode, execute; flags illegal opcodes, counts retirements.
// Build option SINGLE_STEP_EN: FETCH0 advances only on a registered rising edge of step.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)(
    input  logic                clk,
    input  logic                rst_n,
    control_sequencer_if.slave  bus
);

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    dec_t             dec_c;
    logic             go_c;

    opcode_decoder u_dec (
        .opc_i   (bus.instr[OPC_HI:OPC_LO]),
        .dec_c_o (dec_c)
    );

    logic unused_operand;
    assign unused_operand = ^bus.instr[OPC_LO-1:0];

`ifdef SINGLE_STEP_EN
    logic step_q;
    logic pend_q, pend_d;

    // A step rising edge arms one fetch; a held level cannot re-arm it.
    assign go_c = bus.run & pend_q;

    always_comb begin
        pend_d = pend_q;
        if (bus.step & ~step_q) begin
            pend_d = 1'b1;
        end else if ((state_q == S_FETCH0) && go_c) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            step_q <= bus.step;
            pend_q <= pend_d;
        end
    end
`else
    logic unused_step;
    assign unused_step = bus.step;
    assign go_c        = bus.run;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH0: if (go_c) state_d = S_FETCH1;
            S_FETCH1: state_d = S_DECODE;
            S_DECODE: begin
                if (dec_c.legal) begin
                    state_d = dec_c.first;
                end else begin
                    state_d   = S_FETCH0;
                    illegal_d = 1'b1;
                end
            end
            S_SUB0:   state_d = S_SUB1;
            S_SUB1:   state_d = S_SUB2;
            S_ADD0:   state_d = S_ADD1;
            S_ADD1:   state_d = S_ADD2;
            S_XOR0:   state_d = S_XOR1;
            S_XOR1:   state_d = S_XOR2;
            S_LOAD, S_MOVE, S_LDPC, S_BRANCH, S_SUB2, S_ADD2, S_XOR2: begin
                state_d   = S_FETCH0;
                retired_d = retired_q + CNT_W'(1);
            end
            default:  state_d = S_FETCH0;
        endcase
    end

    assign bus.state   = state_q;
    assign bus.done    = is_final(state_q);
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a 4-bit retire counter to exercise wrap.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    control_sequencer_if #(.CNT_W(CNT_W)) bus ();

    control_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction from FETCH0 and check the state/done trace that follows.
    task automatic exec(input string tag, input logic [15:0] ins, input logic [23:0] seq,
                        input int n, input logic [5:0] dmask);
        logic [3:0] exp_st;
        bus.instr = ins;
        bus.run   = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            exp_st = seq[4*i +: 4];
            check_vec({tag, "_state"}, 32'(bus.state), 32'(exp_st));
            check_vec({tag, "_done"}, 32'(bus.done), 32'(dmask[i]));
        end
    endtask

    initial begin
        int f1_cnt;
        logic [CNT_W-1:0] ret0;
        n_vec  = 0;
        n_miss = 0;
        rst_n     = 1'b0;
        bus.run   = 1'b0;
        bus.instr = 16'h0000;
        bus.step  = 1'b0;
        #2;
        check_vec("rst_state", 32'(bus.state), 32'h0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            check_vec("idle_state", 32'(bus.state), 32'h0);
        end
        check_vec("idle_done", 32'(bus.done), 32'h0);
        check_vec("idle_illegal", 32'(bus.illegal), 32'h0);
        check_vec("idle_retired", 32'(bus.retired), 32'h0);

        exec("load", 16'h0120, {4'h0, 4'h2, 4'h1, 4'hF}, 4, 6'b000100);
        exec("move", 16'h1340, {4'h0, 4'h3, 4'h1, 4'hF}, 4, 6'b000100);
        check_vec("ret_after_move", 32'(bus.retired), 32'd2);

        exec("add", 16'h5230, {4'h0, 4'hB, 4'hA, 4'h9, 4'h1, 4'hF}, 6, 6'b010000);
        check_vec("ret_after_add", 32'(bus.retired), 32'd3);

        // run dropped mid-instruction: MOVE completes, later instr changes are ignored
        bus.instr = 16'h1000;
        bus.run   = 1'b1;
        tick();
        bus.run = 1'b0;
        check_vec("drop_f1", 32'(bus.state), 32'hF);
        tick();
        check_vec("drop_dec", 32'(bus.state), 32'h1);
        tick();
        check_vec("drop_move", 32'(bus.state), 32'h3);
        bus.instr = 16'hF000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_vec("drop_hold", 32'(bus.state), 32'h0);
        end
        check_vec("drop_ret", 32'(bus.retired), 32'd4);
        check_vec("drop_illegal", 32'(bus.illegal), 32'h0);

        exec("illegal", 16'h9000, {4'h0, 4'h1, 4'hF}, 3, 6'b000000);
        check_vec("ill_flag", 32'(bus.illegal), 32'h1);
        check_vec("ill_ret", 32'(bus.retired), 32'd4);

        exec("xor", 16'h6120, {4'h0, 4'hE, 4'hD, 4'hC, 4'h1, 4'hF}, 6, 6'b010000);
        check_vec("xor_ret", 32'(bus.retired), 32'd5);
        check_vec("ill_sticky", 32'(bus.illegal), 32'h1);

        exec("ldpc", 16'h2ABC, {4'h0, 4'h4, 4'h1, 4'hF}, 4, 6'b000100);
        exec("branch", 16'h3001, {4'h0, 4'h5, 4'h1, 4'hF}, 4, 6'b000100);
        check_vec("br_ret", 32'(bus.retired), 32'd7);

        // async reset in SUB1, no clock edge in between
        bus.instr = 16'h4000;
        tick(); tick(); tick();
        check_vec("sub0", 32'(bus.state), 32'h6);
        tick();
        check_vec("sub1", 32'(bus.state), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        check_vec("arst_state", 32'(bus.state), 32'h0);
        check_vec("arst_ret", 32'(bus.retired), 32'h0);
        check_vec("arst_illegal", 32'(bus.illegal), 32'h0);
        check_vec("arst_done", 32'(bus.done), 32'h0);
        #3 rst_n = 1'b1;
        bus.run = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            exec("wrap_load", 16'h0000, {4'h0, 4'h2, 4'h1, 4'hF}, 4, 6'b000100);
            if (i == 14) check_vec("wrap_15", 32'(bus.retired), 32'd15);
        end
        check_vec("wrap_0", 32'(bus.retired), 32'd0);
        check_vec("wrap_illegal", 32'(bus.illegal), 32'h0);

`ifdef SINGLE_STEP_EN
        bus.instr = 16'h0000;
        bus.run   = 1'b1;
        bus.step  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_vec("step_wait", 32'(bus.state), 32'h0);
        end
        ret0   = bus.retired;
        f1_cnt = 0;
        bus.step = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.state == 4'hF) f1_cnt++;
        end
        bus.step = 1'b0;
        check_vec("step_once", 32'(f1_cnt), 32'd1);
        check_vec("step_ret", 32'(bus.retired), 32'(ret0 + CNT_W'(1)));
        check_vec("step_idle", 32'(bus.state), 32'h0);
`else
        bus.run  = 1'b0;
        bus.step = 1'b1;
        ret0     = bus.retired;
        f1_cnt   = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.state != 4'h0) f1_cnt++;
        end
        check_vec("step_ignored", 32'(f1_cnt), 32'd0);
        bus.step = 1'b0;
        exec("post_load", 16'h0000, {4'h0, 4'h2, 4'h1, 4'hF}, 4, 6'b000100);
        check_vec("post_ret", 32'(bus.retired), 32'(ret0 + CNT_W'(1)));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
